// File: rtl/vector_dispatch_unit.sv
// ============================================================================
// Module      : vector_dispatch_unit
// Description : Vector-unit front end. An issue queue stamps every accepted
//               instruction with a wrapping ticket, holds the active vl/maxvl
//               configuration and tracks the last producer ticket of each
//               vector register. The queue head is routed to one of NUM_FU
//               functional-unit channels under per-channel valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_dispatch_unit #(
    parameter int IQ_DEPTH    = 4,
    parameter int TICKET_BITS = 4,
    parameter int NUM_FU      = 3,
    parameter int VL_W        = 8,
    parameter int PAYLOAD_W   = 128,
    // Derived widths; not intended to be overridden.
    parameter int FU_W        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    parameter int CNT_W       = $clog2(IQ_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FU_W-1:0]        in_fu,
    input  logic                   in_reconf,
    input  logic                   in_wr_dst,
    input  logic [4:0]             in_dst,
    input  logic [4:0]             in_src1,
    input  logic [4:0]             in_src2,
    input  logic [VL_W-1:0]        in_vl,
    input  logic [VL_W-1:0]        in_maxvl,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    output logic [NUM_FU-1:0]      disp_valid,
    input  logic [NUM_FU-1:0]      disp_ready,
    output logic [TICKET_BITS-1:0] disp_ticket,
    output logic [4:0]             disp_dst,
    output logic [4:0]             disp_src1,
    output logic [4:0]             disp_src2,
    output logic [TICKET_BITS-1:0] disp_last_src1,
    output logic [TICKET_BITS-1:0] disp_last_src2,
    output logic [VL_W-1:0]        disp_vl,
    output logic [VL_W-1:0]        disp_maxvl,
    output logic [PAYLOAD_W-1:0]   disp_payload,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_reg,
    input  logic [TICKET_BITS-1:0] wb_ticket,
    output logic [CNT_W-1:0]       iq_count,
    output logic                   bad_fu_o
);

    localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;

    localparam logic [CNT_W-1:0]       c_depth    = CNT_W'(IQ_DEPTH);
    localparam logic [CNT_W-1:0]       c_cnt_one  = CNT_W'(1);
    localparam logic [PTR_W-1:0]       c_ptr_last = PTR_W'(IQ_DEPTH - 1);
    localparam logic [PTR_W-1:0]       c_ptr_one  = PTR_W'(1);
    localparam logic [TICKET_BITS-1:0] c_tkt_one  = TICKET_BITS'(1);
    localparam logic [TICKET_BITS-1:0] c_tkt_max  = {TICKET_BITS{1'b1}};

    typedef struct packed {
        logic [FU_W-1:0]        fu;
        logic                   reconf;
        logic                   wr_dst;
        logic [4:0]             dst;
        logic [4:0]             src1;
        logic [4:0]             src2;
        logic [VL_W-1:0]        vl;
        logic [VL_W-1:0]        maxvl;
        logic [PAYLOAD_W-1:0]   payload;
        logic [TICKET_BITS-1:0] ticket;
    } entry_t;

    entry_t                 r_mem [IQ_DEPTH];
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [TICKET_BITS-1:0] r_next_ticket;
    logic [VL_W-1:0]        r_vl;
    logic [VL_W-1:0]        r_maxvl;
    logic [TICKET_BITS-1:0] r_prod [32];

    entry_t                 w_head;
    entry_t                 w_new_entry;
    logic                   w_enq;
    logic                   w_pop;
    logic                   w_active;
    logic                   w_head_reconf;
    logic                   w_head_bad;
    logic                   w_fu_ok;
    logic [NUM_FU-1:0]      w_fu_match;
    logic [NUM_FU-1:0]      w_disp_valid;
    logic                   w_disp_fire;
    logic [PTR_W-1:0]       w_rd_ptr_nxt;
    logic [PTR_W-1:0]       w_wr_ptr_nxt;
    logic [TICKET_BITS-1:0] w_ticket_inc;

    // Channel decode of the head: one match bit per implemented channel;
    // a head whose fu matches none of them is a bad route.
    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu_match
            assign w_fu_match[gi] = (w_head.fu == FU_W'(gi));
        end
    endgenerate

    assign w_head        = r_mem[r_rd_ptr];
    assign w_fu_ok       = |w_fu_match;
    assign w_active      = (r_count != '0) & ~flush_i;
    assign w_head_reconf = w_active & w_head.reconf;
    assign w_head_bad    = w_active & ~w_head.reconf & ~w_fu_ok;
    assign w_disp_valid  = w_fu_match & {NUM_FU{w_active & ~w_head.reconf}};
    assign w_disp_fire   = |(w_disp_valid & disp_ready);
    // Reconfigure and badly-routed heads leave without a channel handshake.
    assign w_pop         = w_head_reconf | w_head_bad | w_disp_fire;

    // Acceptance ignores a same-cycle pop so in_ready is a pure register decode.
    assign in_ready      = (r_count < c_depth) & ~flush_i;
    assign w_enq         = in_valid & in_ready;

    assign w_rd_ptr_nxt  = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
    assign w_wr_ptr_nxt  = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
    // Ticket 0 means "no producer", so the counter wraps from all-ones to 1.
    assign w_ticket_inc  = (r_next_ticket == c_tkt_max) ? c_tkt_one
                                                        : r_next_ticket + c_tkt_one;

    // Pack the incoming instruction together with its ticket.
    always_comb begin
        w_new_entry         = '0;
        w_new_entry.fu      = in_fu;
        w_new_entry.reconf  = in_reconf;
        w_new_entry.wr_dst  = in_wr_dst;
        w_new_entry.dst     = in_dst;
        w_new_entry.src1    = in_src1;
        w_new_entry.src2    = in_src2;
        w_new_entry.vl      = in_vl;
        w_new_entry.maxvl   = in_maxvl;
        w_new_entry.payload = in_payload;
        w_new_entry.ticket  = r_next_ticket;
    end

    // Queue storage; occupancy is tracked separately so the data needs no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= w_new_entry;
        end
    end

    // Queue pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_enq && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_enq && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // Ticket allocation; an accepted reconfigure restarts numbering at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_ticket <= c_tkt_one;
        end else if (flush_i) begin
            r_next_ticket <= c_tkt_one;
        end else if (w_enq) begin
            r_next_ticket <= in_reconf ? c_tkt_one : w_ticket_inc;
        end
    end

    // Active vector configuration, taken from a reconfigure head as it pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vl    <= '0;
            r_maxvl <= '0;
        end else if (w_head_reconf) begin
            r_vl    <= w_head.vl;
            r_maxvl <= w_head.maxvl;
        end
    end

    // Last-producer table: a dispatch write beats a same-register writeback clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                r_prod[r] <= '0;
            end
        end else if (flush_i || w_head_reconf) begin
            for (int r = 0; r < 32; r++) begin
                r_prod[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (w_disp_fire && w_head.wr_dst && (w_head.dst == 5'(r))) begin
                    r_prod[r] <= w_head.ticket;
                end else if (wb_valid && (wb_reg == 5'(r)) && (r_prod[r] == wb_ticket)) begin
                    r_prod[r] <= '0;
                end
            end
        end
    end

    assign disp_valid     = w_disp_valid;
    assign disp_ticket    = w_head.ticket;
    assign disp_dst       = w_head.dst;
    assign disp_src1      = w_head.src1;
    assign disp_src2      = w_head.src2;
    assign disp_last_src1 = r_prod[w_head.src1];
    assign disp_last_src2 = r_prod[w_head.src2];
    assign disp_vl        = r_vl;
    assign disp_maxvl     = r_maxvl;
    assign disp_payload   = w_head.payload;
    assign iq_count       = r_count;
    assign bad_fu_o       = w_head_bad;

endmodule

`default_nettype wire

// File: tb/tb_vector_dispatch_unit.sv
// ============================================================================
// Module      : tb_vector_dispatch_unit
// Description : Self-checking bench for vector_dispatch_unit. A queue-based
//               reference model predicts every output each cycle; directed
//               scenarios add literal expectations, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_dispatch_unit;

    localparam int IQ_DEPTH = 4;
    localparam int NUM_FU   = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush_i;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_fu;
    logic         in_reconf;
    logic         in_wr_dst;
    logic [4:0]   in_dst, in_src1, in_src2;
    logic [7:0]   in_vl, in_maxvl;
    logic [127:0] in_payload;
    logic [2:0]   disp_valid;
    logic [2:0]   disp_ready;
    logic [3:0]   disp_ticket;
    logic [4:0]   disp_dst, disp_src1, disp_src2;
    logic [3:0]   disp_last_src1, disp_last_src2;
    logic [7:0]   disp_vl, disp_maxvl;
    logic [127:0] disp_payload;
    logic         wb_valid;
    logic [4:0]   wb_reg;
    logic [3:0]   wb_ticket;
    logic [2:0]   iq_count;
    logic         bad_fu_o;

    vector_dispatch_unit dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_fu(in_fu),
        .in_reconf(in_reconf), .in_wr_dst(in_wr_dst),
        .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
        .in_vl(in_vl), .in_maxvl(in_maxvl), .in_payload(in_payload),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_ticket(disp_ticket), .disp_dst(disp_dst),
        .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_last_src1(disp_last_src1), .disp_last_src2(disp_last_src2),
        .disp_vl(disp_vl), .disp_maxvl(disp_maxvl), .disp_payload(disp_payload),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_ticket(wb_ticket),
        .iq_count(iq_count), .bad_fu_o(bad_fu_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int           fu;
        bit           reconf;
        bit           wr;
        int           dst, s1, s2;
        int           vl, mvl;
        logic [127:0] pl;
        int           tk;
    } ent_t;

    ent_t q[$];
    int   m_tbl[32];
    int   m_next;
    int   m_vl, m_mvl;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        foreach (m_tbl[r]) m_tbl[r] = 0;
        m_next = 1;
        m_vl   = 0;
        m_mvl  = 0;
    endfunction

    // Expected outputs for the current cycle from model state plus live inputs.
    function automatic void compare();
        int dv  = 0;
        bit bad = 0;
        chk("in_ready", in_ready, (q.size() < IQ_DEPTH) && !flush_i);
        chk("iq_count", iq_count, q.size());
        if (q.size() != 0 && !flush_i && !q[0].reconf) begin
            if (q[0].fu < NUM_FU) dv = 1 << q[0].fu;
            else                  bad = 1;
        end
        chk("disp_valid", disp_valid, dv);
        chk("bad_fu_o", bad_fu_o, bad);
        chk("disp_vl", disp_vl, m_vl);
        chk("disp_maxvl", disp_maxvl, m_mvl);
        if (dv != 0) begin
            chk("disp_ticket", disp_ticket, q[0].tk);
            chk("disp_dst", disp_dst, q[0].dst);
            chk("disp_src1", disp_src1, q[0].s1);
            chk("disp_src2", disp_src2, q[0].s2);
            chk("disp_last_src1", disp_last_src1, m_tbl[q[0].s1]);
            chk("disp_last_src2", disp_last_src2, m_tbl[q[0].s2]);
            chk("disp_payload", disp_payload, q[0].pl);
        end
    endfunction

    // State change at a clock edge, decided from the inputs held over that edge.
    function automatic void model_update();
        int   nt[32];
        bit   pop = 0;
        bit   acc;
        ent_t h;
        ent_t e;
        if (flush_i) begin
            model_reset_keep_cfg();
            return;
        end
        nt = m_tbl;
        if (wb_valid && m_tbl[wb_reg] == int'(wb_ticket)) nt[wb_reg] = 0;
        if (q.size() != 0) begin
            h = q[0];
            if (h.reconf) begin
                pop   = 1;
                m_vl  = h.vl;
                m_mvl = h.mvl;
                foreach (nt[r]) nt[r] = 0;
            end else if (h.fu >= NUM_FU) begin
                pop = 1;
            end else if (disp_ready[h.fu]) begin
                pop = 1;
                if (h.wr) nt[h.dst] = h.tk;
            end
        end
        acc = in_valid && (q.size() < IQ_DEPTH);
        if (pop) void'(q.pop_front());
        if (acc) begin
            e.fu = in_fu; e.reconf = in_reconf; e.wr = in_wr_dst;
            e.dst = in_dst; e.s1 = in_src1; e.s2 = in_src2;
            e.vl = in_vl; e.mvl = in_maxvl; e.pl = in_payload; e.tk = m_next;
            q.push_back(e);
            if (in_reconf)        m_next = 1;
            else if (m_next == 15) m_next = 1;
            else                  m_next = m_next + 1;
        end
        m_tbl = nt;
    endfunction

    function automatic void model_reset_keep_cfg();
        q.delete();
        foreach (m_tbl[r]) m_tbl[r] = 0;
        m_next = 1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        flush_i = 0; in_valid = 0; in_fu = 0; in_reconf = 0; in_wr_dst = 0;
        in_dst = 0; in_src1 = 0; in_src2 = 0; in_vl = 0; in_maxvl = 0;
        in_payload = '0; disp_ready = 3'b111; wb_valid = 0; wb_reg = 0; wb_ticket = 0;
    endtask

    task automatic put(input bit v, input int fu, input bit rc, input bit wr,
                       input int dst, input int s1, input int s2);
        in_valid = v; in_fu = 2'(fu); in_reconf = rc; in_wr_dst = wr;
        in_dst = 5'(dst); in_src1 = 5'(s1); in_src2 = 5'(s2);
        in_vl = 8'($urandom); in_maxvl = 8'($urandom);
        in_payload = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic settle();
        #1;
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_iq_count", iq_count, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_bad_fu", bad_fu_o, 0);
        chk("rst_vl", {disp_vl, disp_maxvl}, 0);
        rst_n = 1;

        // Three instructions to channels 1,0,2 with every channel ready.
        put(1, 1, 0, 0, 1, 2, 3); settle(); advance();
        put(1, 0, 0, 0, 4, 5, 6); settle();
        chk("s1_valid0", disp_valid, 3'b010); chk("s1_tk0", disp_ticket, 1); advance();
        put(1, 2, 0, 0, 7, 1, 2); settle();
        chk("s1_valid1", disp_valid, 3'b001); chk("s1_tk1", disp_ticket, 2); advance();
        in_valid = 0; settle();
        chk("s1_valid2", disp_valid, 3'b100); chk("s1_tk2", disp_ticket, 3); advance();
        settle(); chk("s1_count", iq_count, 0); advance();

        // Stall all channels, fill the queue, then drain in order.
        disp_ready = 3'b000;
        for (int k = 0; k < IQ_DEPTH; k++) begin
            put(1, k % 3, 0, 1, k + 8, k, k + 1); settle(); advance();
        end
        put(1, 0, 0, 0, 0, 0, 0); settle();
        chk("full_ready", in_ready, 0); chk("full_count", iq_count, IQ_DEPTH); advance();
        in_valid = 0; settle(); advance();
        disp_ready = 3'b111;
        for (int k = 0; k < IQ_DEPTH + 1; k++) begin settle(); advance(); end

        // Ticket wrap: start from a clean numbering, 16 plain instructions.
        flush_i = 1; settle(); advance(); flush_i = 0;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) put(1, $urandom_range(0, 2), 0, 0, 1, 1, 1); else in_valid = 0;
            settle();
            if (k >= 1) chk("wrap_ticket", disp_ticket, ((k - 1) % 15) + 1);
            advance();
        end

        // Reconfigure vl=32 maxvl=64, then an instruction sees it and ticket 1.
        put(1, 0, 1, 0, 0, 0, 0); in_vl = 8'd32; in_maxvl = 8'd64; settle(); advance();
        put(1, 1, 0, 0, 2, 2, 2); settle();
        chk("reconf_novalid", disp_valid, 0); advance();
        in_valid = 0; settle();
        chk("reconf_vl", disp_vl, 32); chk("reconf_maxvl", disp_maxvl, 64);
        chk("reconf_ticket", disp_ticket, 1); advance();

        // Producer tracking around v3.
        flush_i = 1; put(1, 0, 0, 1, 3, 0, 0); settle();
        chk("flush_ready", in_ready, 0); advance(); flush_i = 0;
        put(1, 0, 0, 1, 3, 0, 0); settle(); advance();          // A: dst v3, ticket 1
        put(1, 1, 0, 0, 9, 3, 4); settle(); advance();          // B: src1 v3, ticket 2
        in_valid = 0; disp_ready = 3'b000;
        wb_valid = 1; wb_reg = 5'd3; wb_ticket = 4'd2; settle();
        chk("prod_src1", disp_last_src1, 1); advance();
        wb_ticket = 4'd1; settle();
        chk("prod_wrong_wb", disp_last_src1, 1); advance();
        wb_valid = 0; settle();
        chk("prod_cleared", disp_last_src1, 0);
        disp_ready = 3'b111; put(1, 0, 0, 1, 3, 0, 0); advance(); // C: ticket 3
        put(1, 0, 0, 1, 3, 0, 0); settle(); advance();            // D: ticket 4
        put(1, 2, 0, 0, 9, 3, 3); wb_valid = 1; wb_reg = 5'd3; wb_ticket = 4'd3;
        settle(); advance();                                      // D fires with wb v3/3
        in_valid = 0; wb_valid = 0; settle();
        chk("prod_write_wins", disp_last_src1, 4); advance();

        // Flush with three queued entries and an offered instruction.
        disp_ready = 3'b000;
        for (int k = 0; k < 3; k++) begin put(1, 1, 0, 1, 3, 3, 3); settle(); advance(); end
        flush_i = 1; put(1, 1, 0, 1, 3, 3, 3); settle();
        chk("flush_novalid", disp_valid, 0); advance();
        flush_i = 0; in_valid = 0; disp_ready = 3'b111; settle();
        chk("flush_count", iq_count, 0); chk("flush_vl", disp_vl, 32);
        put(1, 1, 0, 0, 0, 3, 3); advance();
        in_valid = 0; settle();
        chk("flush_ticket", disp_ticket, 1); chk("flush_table", disp_last_src1, 0); advance();

        // Badly routed head: dropped in one cycle, its dst not recorded.
        put(1, 3, 0, 1, 5, 0, 0); settle(); advance();
        put(1, 0, 0, 0, 0, 5, 5); settle();
        chk("bad_pulse", bad_fu_o, 1); chk("bad_novalid", disp_valid, 0); advance();
        in_valid = 0; settle();
        chk("bad_gone", bad_fu_o, 0); chk("bad_not_recorded", disp_last_src1, 0); advance();

        // Random traffic with an asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            put(($urandom % 4) != 0, ($urandom % 8 == 0) ? 3 : $urandom_range(0, 2),
                ($urandom % 12) == 0, ($urandom % 4) != 0,
                $urandom % 8, $urandom % 8, $urandom % 8);
            flush_i    = ($urandom % 40) == 0;
            disp_ready = 3'($urandom);
            wb_valid   = ($urandom % 3) == 0;
            wb_reg     = 5'($urandom % 8);
            wb_ticket  = ($urandom % 2) ? 4'(m_tbl[wb_reg]) : 4'($urandom);
            settle();
            advance();
            if (c == 1500) begin
                idle();
                #2 rst_n = 0;
                #1;
                chk("arst_count", iq_count, 0);
                chk("arst_valid", disp_valid, 0);
                chk("arst_vl", disp_vl, 0);
                model_reset();
                rst_n = 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
